uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequences the UART receive SIPO: tracks frame progress via active_flag/recieved_flag, validates each
//  captured 11-bit frame (start, 8 data, parity, stop), and buffers good bytes in a 4-entry FIFO with a
//  valid/ready handshake to the host. Keeps sticky overrun/timeout status and a saturating error count.
//  Sits between SIPO and the host/bus interface, same baud_clk (16x oversample) domain.
// PARAMETERS
//  PARITY_EN    1    1: data_parll[9] is parity and is checked; 0: bit 9 ignored
//  PARITY_ODD   0    1: odd parity, 0: even parity (over data bits + parity bit)
//  TIMEOUT_CYC  192  max baud_clk cycles in RECV before timeout (12 bit-times at 16x)
//  ERR_CNT_W    8    width of err_count
// PORTS
//  baud_clk       in   1          system clock (16x baud)
//  reset_n        in   1          synchronous active-low reset
//  active_flag    in   1          SIPO frame-in-progress
//  recieved_flag  in   1          SIPO one-cycle frame-complete strobe
//  data_parll     in   11         SIPO frame: [0]start [8:1]data LSB-first [9]parity [10]stop
//  rx_ready       in   1          host accepts rx_data this cycle
//  clr_status     in   1          clears overrun, timeout_err, err_count
//  rx_data        out  8          FIFO head byte
//  rx_perr        out  1          FIFO head parity error tag
//  rx_ferr        out  1          FIFO head stop-bit error tag
//  rx_valid       out  1          FIFO non-empty
//  busy           out  1          FSM not in IDLE
//  overrun        out  1          sticky: frame dropped, FIFO full
//  timeout_err    out  1          sticky: RECV exceeded TIMEOUT_CYC
//  err_count      out  ERR_CNT_W  saturating count of all error events
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): FSM=IDLE, FIFO empty, all outputs 0, timeout counter 0. Mid-frame reset
//    discards the frame; FIFO contents lost.
//  - FSM: IDLE -> RECV on active_flag=1; IDLE/RECV -> CHECK on recieved_flag=1 (strobe wins over
//    active_flag); CHECK -> IDLE after one cycle; RECV -> FLUSH when timer reaches TIMEOUT_CYC;
//    FLUSH -> IDLE when active_flag=0. recieved_flag in FLUSH is ignored.
//  - Timer counts every cycle in RECV, cleared on any other state.
//  - Capture: data_parll latched on the cycle recieved_flag=1; CHECK evaluates the latched copy.
//  - CHECK: start bit=1 -> false start: frame dropped, err_count+1. Else perr=PARITY_EN &
//    (^data_parll[9:1] != PARITY_ODD); ferr=~data_parll[10]. Frame pushed with tags; perr or ferr
//    each add 1 to err_count (both -> +2, saturating).
//  - Latency: strobe sampled at edge N, push at edge N+1, rx_valid=1 from edge N+1 (empty FIFO).
//  - FIFO: 4 entries x 10 bits {ferr,perr,data}, 2-bit wrapping pointers + count. Pop when
//    rx_valid & rx_ready. Push when full and no pop same cycle -> drop, overrun=1, err_count+1.
//    Full with simultaneous pop -> push accepted. Pop on empty ignored.
//  - Timeout: entering FLUSH sets timeout_err, err_count+1.
//  - err_count saturates at all-ones. clr_status clears sticky bits/counter; an error event in the same
//    cycle wins (flag=1, count=1 or 2).
//  - busy=1 in RECV, CHECK, FLUSH.
// TESTING
//  1. Frame 0x55, even parity, stop=1 (data_parll=11'b1_0_01010101_0), strobe -> rx_valid next
//     edge, rx_data=8'h55, rx_perr=0, rx_ferr=0, err_count=0.
//  2. Same frame with parity bit flipped -> rx_data=8'h55, rx_perr=1, err_count=1; then stop=0 ->
//     rx_ferr=1, err_count=2.
//  3. rx_ready=0, five good frames 0x01..0x05 -> FIFO holds 01..04, overrun=1, err_count=1; drain ->
//     01,02,03,04 in order; clr_status -> overrun=0, err_count=0.
//  4. Full FIFO, strobe and rx_ready=1 same cycle -> no overrun, count stays 4, new byte at tail.
//  5. active_flag held 1 for 200 cycles without strobe -> timeout_err=1 at cycle 192, busy until
//     active_flag=0, strobe during FLUSH ignored.
//  6. reset_n=0 mid-RECV with 2 bytes queued -> next edge rx_valid=0, busy=0, all flags 0.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Tracks SIPO frame progress, validates captured frames (start/parity/stop),
// queues good bytes in a 4-deep FIFO for the host, and keeps sticky
// overrun/timeout status plus a saturating error counter.
module uart_rx_frame_ctrl #(
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0,
  parameter int TIMEOUT_CYC = 192,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 active_flag,
  input  logic                 recieved_flag,
  input  logic [10:0]          data_parll,
  input  logic                 rx_ready,
  input  logic                 clr_status,
  output logic [7:0]           rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ERR_CNT_W+1:0] ERR_MAX = {2'b00, {ERR_CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_FLUSH
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [10:0]          frame_q, frame_d;
  logic [9:0]           mem_q [4];
  logic [9:0]           mem_d [4];
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [2:0]           count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 busy_q, busy_d;

  logic                 timeout_evt;
  logic                 false_start, push_req, perr, ferr;
  logic                 pop, full, push, ovr_evt;
  logic [2:0]           err_inc;
  logic [ERR_CNT_W-1:0] err_base;
  logic [ERR_CNT_W+1:0] err_sum;

  // Frame sequencing, frame capture and RECV timeout timer
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    frame_d     = frame_q;
    timeout_evt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (recieved_flag) begin
          state_d = S_CHECK;
          frame_d = data_parll;
        end else if (active_flag) begin
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (recieved_flag) begin
          state_d = S_CHECK;
          frame_d = data_parll;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d     = S_FLUSH;
          timeout_evt = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CHECK: state_d = S_IDLE;
      S_FLUSH: if (!active_flag) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Frame validation and FIFO push/pop bookkeeping
  always_comb begin
    false_start = (state_q == S_CHECK) & frame_q[0];
    push_req    = (state_q == S_CHECK) & ~frame_q[0];
    perr        = (PARITY_EN != 0) & ((^frame_q[9:1]) != (PARITY_ODD != 0));
    ferr        = ~frame_q[10];
    pop         = (count_q != 3'd0) & rx_ready;
    full        = (count_q == 3'd4);
    // a full FIFO still accepts the push when the head leaves the same cycle
    push        = push_req & (~full | pop);
    ovr_evt     = push_req & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {ferr, perr, frame_q[8:1]};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Sticky status and saturating error count; a same-cycle event beats clr_status
  always_comb begin
    err_inc     = 3'(false_start) + 3'(push_req & perr) + 3'(push_req & ferr)
                + 3'(ovr_evt) + 3'(timeout_evt);
    err_base    = clr_status ? '0 : err_count_q;
    err_sum     = {2'b00, err_base} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
    err_count_d = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_CNT_W-1:0];
    overrun_d   = ovr_evt | (overrun_q & ~clr_status);
    timeout_d   = timeout_evt | (timeout_q & ~clr_status);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge baud_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      frame_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_q     <= frame_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q][7:0];
  assign rx_perr     = mem_q[rd_ptr_q][8];
  assign rx_ferr     = mem_q[rd_ptr_q][9];
  assign rx_valid    = (count_q != 3'd0);
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_uart_rx_frame_ctrl;

  localparam int PARITY_EN   = 1;
  localparam int PARITY_ODD  = 0;
  localparam int TIMEOUT_CYC = 192;
  localparam int ERR_CNT_W   = 8;
  localparam int ERR_MAXV    = (1 << ERR_CNT_W) - 1;

  logic                 baud_clk;
  logic                 reset_n;
  logic                 active_flag;
  logic                 recieved_flag;
  logic [10:0]          data_parll;
  logic                 rx_ready;
  logic                 clr_status;
  logic [7:0]           rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 busy;
  logic                 overrun;
  logic                 timeout_err;
  logic [ERR_CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  uart_rx_frame_ctrl #(
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .baud_clk     (baud_clk),
    .reset_n      (reset_n),
    .active_flag  (active_flag),
    .recieved_flag(recieved_flag),
    .data_parll   (data_parll),
    .rx_ready     (rx_ready),
    .clr_status   (clr_status),
    .rx_data      (rx_data),
    .rx_perr      (rx_perr),
    .rx_ferr      (rx_ferr),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .err_count    (err_count)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0]  m_q[$];
  bit          m_pend, m_recv, m_flush;
  logic [10:0] m_frame;
  int          m_cycles;
  bit          m_ovr, m_to;
  int          m_err;

  always @(posedge baud_clk) begin
    int   ev;
    bit   ovr_ev, to_ev, do_pop, do_push, pe, fe;
    logic [9:0] item;
    if (!reset_n) begin
      m_q.delete();
      m_pend = 0; m_recv = 0; m_flush = 0; m_cycles = 0;
      m_ovr = 0; m_to = 0; m_err = 0;
    end else begin
      ev = 0; ovr_ev = 0; to_ev = 0; do_push = 0; item = '0;
      do_pop = (m_q.size() != 0) && rx_ready;
      if (m_pend) begin
        if (m_frame[0]) ev++;
        else begin
          pe = (PARITY_EN != 0) && (($countones(m_frame[9:1]) % 2) != PARITY_ODD);
          fe = !m_frame[10];
          ev += int'(pe) + int'(fe);
          if (m_q.size() == 4 && !do_pop) begin
            ovr_ev = 1; ev++;
          end else begin
            do_push = 1; item = {fe, pe, m_frame[8:1]};
          end
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(item);

      if (m_pend) m_pend = 0;
      else if (m_flush) begin
        if (!active_flag) m_flush = 0;
      end else if (recieved_flag) begin
        m_pend = 1; m_frame = data_parll; m_recv = 0;
      end else if (m_recv) begin
        m_cycles++;
        if (m_cycles == TIMEOUT_CYC) begin
          m_recv = 0; m_flush = 1; to_ev = 1; ev++;
        end
      end else if (active_flag) begin
        m_recv = 1; m_cycles = 0;
      end

      m_ovr = ovr_ev || (m_ovr && !clr_status);
      m_to  = to_ev || (m_to && !clr_status);
      if (clr_status) m_err = 0;
      m_err = (m_err + ev > ERR_MAXV) ? ERR_MAXV : m_err + ev;
    end
  end

  // every-cycle comparison against the model, 1 time unit after the edge
  initial begin
    forever begin
      @(posedge baud_clk);
      #1;
      if (cmp_en) begin
        chk("rx_valid", 32'(rx_valid), 32'(m_q.size() != 0));
        chk("busy", 32'(busy), 32'(m_pend || m_recv || m_flush));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        chk("err_count", 32'(err_count), 32'(m_err));
        if (m_q.size() != 0) begin
          chk("rx_data", 32'(rx_data), 32'(m_q[0][7:0]));
          chk("rx_perr", 32'(rx_perr), 32'(m_q[0][8]));
          chk("rx_ferr", 32'(rx_ferr), 32'(m_q[0][9]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [10:0] mk(input logic [7:0] d, input logic pinj, input logic stop);
    logic p;
    p = (^d) ^ (PARITY_ODD != 0) ^ pinj;
    return {stop, p, d, 1'b0};
  endfunction

  // one frame: RECV for a cycle, strobe, then the CHECK cycle; returns at the
  // negedge after the push edge
  task automatic send(input logic [10:0] f, input logic rdy_chk, input logic clr_chk);
    active_flag = 1'b1;
    @(negedge baud_clk);
    active_flag   = 1'b0;
    recieved_flag = 1'b1;
    data_parll    = f;
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    rx_ready      = rdy_chk;
    clr_status    = clr_chk;
    @(negedge baud_clk);
    rx_ready   = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic pop1();
    rx_ready = 1'b1;
    @(negedge baud_clk);
    rx_ready = 1'b0;
  endtask

  task automatic clr1();
    clr_status = 1'b1;
    @(negedge baud_clk);
    clr_status = 1'b0;
  endtask

  function automatic logic [10:0] rand_frame();
    logic [7:0] d;
    d = 8'($urandom);
    return mk(d, ($urandom % 6) == 0, ($urandom % 6) != 0) | 11'(($urandom % 16) == 0);
  endfunction

  initial begin
    int act_left;
    reset_n = 1'b0; active_flag = 1'b0; recieved_flag = 1'b0;
    data_parll = '0; rx_ready = 1'b0; clr_status = 1'b0;
    repeat (3) @(negedge baud_clk);
    cmp_en = 1;

    // reset state
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst rx_data", 32'(rx_data), 32'd0);
    reset_n = 1'b1;
    @(negedge baud_clk);

    // good frame 0x55, even parity
    send(11'b1_0_01010101_0, 1'b0, 1'b0);
    chk("t1 rx_valid", 32'(rx_valid), 32'd1);
    chk("t1 rx_data", 32'(rx_data), 32'h55);
    chk("t1 rx_perr", 32'(rx_perr), 32'd0);
    chk("t1 rx_ferr", 32'(rx_ferr), 32'd0);
    chk("t1 err_count", 32'(err_count), 32'd0);
    pop1();
    chk("t1 popped", 32'(rx_valid), 32'd0);

    // parity error, then stop-bit error
    send(11'b1_1_01010101_0, 1'b0, 1'b0);
    chk("t2 rx_data", 32'(rx_data), 32'h55);
    chk("t2 rx_perr", 32'(rx_perr), 32'd1);
    chk("t2 err_count", 32'(err_count), 32'd1);
    pop1();
    send(11'b0_0_01010101_0, 1'b0, 1'b0);
    chk("t2 rx_ferr", 32'(rx_ferr), 32'd1);
    chk("t2 rx_perr2", 32'(rx_perr), 32'd0);
    chk("t2 err_count2", 32'(err_count), 32'd2);
    pop1();
    clr1();
    chk("t2 clr", 32'(err_count), 32'd0);

    // overrun on the fifth frame
    for (int i = 1; i <= 5; i++) send(mk(8'(i), 1'b0, 1'b1), 1'b0, 1'b0);
    chk("t3 overrun", 32'(overrun), 32'd1);
    chk("t3 err_count", 32'(err_count), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3 drain", 32'(rx_data), 32'(i));
      pop1();
    end
    chk("t3 empty", 32'(rx_valid), 32'd0);
    clr1();
    chk("t3 clr overrun", 32'(overrun), 32'd0);
    chk("t3 clr err", 32'(err_count), 32'd0);

    // full FIFO with push and pop on the same edge
    for (int i = 0; i < 4; i++) send(mk(8'(8'h10 + i), 1'b0, 1'b1), 1'b0, 1'b0);
    send(mk(8'h14, 1'b0, 1'b1), 1'b1, 1'b0);
    chk("t4 overrun", 32'(overrun), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("t4 drain", 32'(rx_data), 32'(8'h10 + i));
      pop1();
    end
    chk("t4 empty", 32'(rx_valid), 32'd0);

    // timeout: 192 cycles in RECV, then FLUSH ignores a strobe
    active_flag = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge baud_clk);
      if (i == 192) begin
        chk("t5 no timeout yet", 32'(timeout_err), 32'd0);
        chk("t5 busy recv", 32'(busy), 32'd1);
      end
      if (i == 193) begin
        chk("t5 timeout", 32'(timeout_err), 32'd1);
        chk("t5 err_count", 32'(err_count), 32'd1);
      end
      recieved_flag = (i == 195);
      data_parll    = mk(8'h77, 1'b0, 1'b1);
    end
    chk("t5 busy flush", 32'(busy), 32'd1);
    active_flag = 1'b0;
    @(negedge baud_clk);
    chk("t5 idle", 32'(busy), 32'd0);
    chk("t5 strobe ignored", 32'(rx_valid), 32'd0);

    // reset mid-RECV with two queued bytes and status set
    send(mk(8'hA1, 1'b1, 1'b1), 1'b0, 1'b0);
    send(mk(8'hA2, 1'b0, 1'b1), 1'b0, 1'b0);
    active_flag = 1'b1;
    @(negedge baud_clk);
    chk("t6 busy", 32'(busy), 32'd1);
    chk("t6 err before", 32'(err_count), 32'd2);
    reset_n = 1'b0;
    @(negedge baud_clk);
    reset_n = 1'b1; active_flag = 1'b0;
    chk("t6 rx_valid", 32'(rx_valid), 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 timeout", 32'(timeout_err), 32'd0);
    chk("t6 err_count", 32'(err_count), 32'd0);
    @(negedge baud_clk);

    // clear in the same cycle as a double error: count restarts at 2
    send(mk(8'h3C, 1'b1, 1'b1), 1'b0, 1'b0);
    send(mk(8'h3D, 1'b1, 1'b0), 1'b0, 1'b1);
    chk("t7 clr+err", 32'(err_count), 32'd2);
    pop1(); pop1();

    // saturation
    for (int i = 0; i < 100; i++) send(mk(8'(i), 1'b1, 1'b0), 1'b0, 1'b0);
    chk("t8 saturate", 32'(err_count), 32'(ERR_MAXV));
    chk("t8 overrun", 32'(overrun), 32'd1);

    // randomized traffic
    act_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge baud_clk);
      rx_ready      = ($urandom % 10) < 6;
      clr_status    = ($urandom % 50) == 0;
      reset_n       = ($urandom % 900) != 0;
      recieved_flag = 1'b0;
      if (act_left > 0) begin
        act_left--;
        active_flag = 1'b1;
        if (act_left == 0) begin
          active_flag   = 1'b0;
          recieved_flag = 1'b1;
          data_parll    = rand_frame();
        end
      end else begin
        active_flag = 1'b0;
        if (($urandom % 4) == 0)
          act_left = (($urandom % 16) == 0) ? 150 + int'($urandom % 80) : 1 + int'($urandom % 14);
      end
    end
    @(negedge baud_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
